alu_decode_stage: RTL and testbench

ID/EX pipeline stage directly upstream of the 16-bit ALU. It accepts fetched 16-bit instructions over a valid/ready handshake and reads the register file. It resolves operands, with write-back forwarding and r0 hardwired to zero, then registers src_1, src_2, a 4-bit alu_control, the destination and write-enable for the execute stage. A 2-entry elastic buffer (main + skid) keeps in_ready registered while the execute stage back-pressures.

---
 rtl/alu_decode_stage.sv | 156 +++++++++++++++
 tb/tb_alu_decode_stage.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_stage.sv
// ID/EX stage in front of the 16-bit ALU: decodes instructions, resolves operands
// (r0 = 0, write-back forwarding) and holds them in a main + skid elastic buffer.
module alu_decode_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int IMM_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_instr,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              fwd_valid,
  input  logic [REG_AW-1:0] fwd_rd,
  input  logic [DATA_W-1:0] fwd_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] src_1,
  output logic [DATA_W-1:0] src_2,
  output logic [3:0]        alu_control,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_reg_write,
  output logic              out_illegal
);

  typedef struct packed {
    logic [DATA_W-1:0] src_1;
    logic [DATA_W-1:0] src_2;
    logic [3:0]        alu_control;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              illegal;
  } op_t;

  // r0 wins over forwarding, forwarding wins over the register file.
  function automatic logic [DATA_W-1:0] resolve(
    input logic [REG_AW-1:0] r,
    input logic [DATA_W-1:0] rf,
    input logic              f_valid,
    input logic [REG_AW-1:0] f_rd,
    input logic [DATA_W-1:0] f_data
  );
    if (r == '0) return '0;
    else if (f_valid && (f_rd == r)) return f_data;
    else return rf;
  endfunction

  logic [3:0]        opcode;
  logic [REG_AW-1:0] rd_field;
  logic [IMM_W-1:0]  imm_field;
  logic [DATA_W-1:0] opnd_1;
  logic [DATA_W-1:0] opnd_2;
  op_t               dec;

  assign opcode    = in_instr[15:12];
  assign rd_field  = in_instr[11:9];
  assign imm_field = in_instr[IMM_W-1:0];
  assign rf_raddr1 = in_instr[8:6];
  assign rf_raddr2 = in_instr[5:3];
  assign opnd_1    = resolve(rf_raddr1, rf_rdata1, fwd_valid, fwd_rd, fwd_data);
  assign opnd_2    = resolve(rf_raddr2, rf_rdata2, fwd_valid, fwd_rd, fwd_data);

  always_comb begin
    dec             = '0;
    dec.rd          = rd_field;
    dec.reg_write   = (opcode <= 4'h9) && (rd_field != '0);
    unique case (opcode)
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6: begin
        dec.alu_control = opcode;
        dec.src_1       = opnd_1;
        dec.src_2       = opnd_2;
      end
      4'h2, 4'h7, 4'h8: begin
        dec.alu_control = opcode;
        dec.src_1       = opnd_1;
      end
      4'h9: begin
        dec.src_1 = opnd_1;
        dec.src_2 = {{(DATA_W-IMM_W){imm_field[IMM_W-1]}}, imm_field};
      end
      4'hF: ;
      default: dec.illegal = 1'b1;
    endcase
  end

  logic main_valid_q, main_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic in_ready_q, in_ready_d;
  op_t  main_q, main_d;
  op_t  skid_q, skid_d;
  logic accept;
  logic main_free;

  assign accept    = in_valid && in_ready_q && !flush;
  assign main_free = !main_valid_q || out_ready;

  // Main is refilled from skid first so ordering stays FIFO; a new op lands
  // in main only when skid is empty, otherwise it queues behind in skid.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = dec;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = main_valid_q;
  assign src_1         = main_q.src_1;
  assign src_2         = main_q.src_2;
  assign alu_control   = main_q.alu_control;
  assign out_rd        = main_q.rd;
  assign out_reg_write = main_q.reg_write;
  assign out_illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed, table-driven bench for alu_decode_stage plus hand-written
// back-pressure, flush and mid-stall reset sequences.
module tb_alu_decode_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic [2:0]  rf_raddr1;
  logic [2:0]  rf_raddr2;
  logic [15:0] rf_rdata1;
  logic [15:0] rf_rdata2;
  logic        fwd_valid;
  logic [2:0]  fwd_rd;
  logic [15:0] fwd_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] src_1;
  logic [15:0] src_2;
  logic [3:0]  alu_control;
  logic [2:0]  out_rd;
  logic        out_reg_write;
  logic        out_illegal;

  alu_decode_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .src_1(src_1), .src_2(src_2), .alu_control(alu_control),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_illegal(out_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [15:0] instr;
    logic [15:0] rdata1;
    logic [15:0] rdata2;
    logic        fv;
    logic [2:0]  frd;
    logic [15:0] fdata;
    logic [15:0] e_src1;
    logic [15:0] e_src2;
    logic [3:0]  e_ctrl;
    logic [2:0]  e_rd;
    logic        e_rw;
    logic        e_ill;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];
  int   vec_count  = 0;
  int   miss_count = 0;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    in_instr  = v.instr;
    rf_rdata1 = v.rdata1;
    rf_rdata2 = v.rdata2;
    fwd_valid = v.fv;
    fwd_rd    = v.frd;
    fwd_data  = v.fdata;
  endtask

  task automatic checkDecoded(input string tag, input vec_t v);
    checkOutput({tag, " out_valid"}, {15'd0, out_valid}, 16'd1);
    checkOutput({tag, " src_1"}, src_1, v.e_src1);
    checkOutput({tag, " src_2"}, src_2, v.e_src2);
    checkOutput({tag, " alu_control"}, {12'd0, alu_control}, {12'd0, v.e_ctrl});
    checkOutput({tag, " out_rd"}, {13'd0, out_rd}, {13'd0, v.e_rd});
    checkOutput({tag, " reg_write"}, {15'd0, out_reg_write}, {15'd0, v.e_rw});
    checkOutput({tag, " illegal"}, {15'd0, out_illegal}, {15'd0, v.e_ill});
  endtask

  task automatic fillMainAndSkid(input logic [15:0] a_val, input logic [15:0] b_val);
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b0;
    in_instr = 16'h0298; rf_rdata1 = a_val; rf_rdata2 = 16'h0001; fwd_valid = 1'b0;
    @(negedge clk);
    rf_rdata1 = b_val;
    @(negedge clk);
  endtask

  vec_t op_a, op_b, op_c;

  initial begin
    //              instr     rd1      rd2      fv  frd   fdata    src1     src2     ctl   rd   rw  ill
    vecs[0]  = '{16'h0298, 16'h0005, 16'h0007, 0, 3'd0, 16'h0000, 16'h0005, 16'h0007, 4'h0, 3'd1, 1, 0};
    vecs[1]  = '{16'h94FF, 16'h0010, 16'h3333, 0, 3'd0, 16'h0000, 16'h0010, 16'hFFFF, 4'h0, 3'd2, 1, 0};
    vecs[2]  = '{16'h2940, 16'h1234, 16'h5555, 0, 3'd0, 16'h0000, 16'h1234, 16'h0000, 4'h2, 3'd4, 1, 0};
    vecs[3]  = '{16'h1280, 16'h1111, 16'h7777, 1, 3'd2, 16'hBEEF, 16'hBEEF, 16'h0000, 4'h1, 3'd1, 1, 0};
    vecs[4]  = '{16'hC000, 16'h4444, 16'h5555, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 3'd0, 0, 1};
    vecs[5]  = '{16'h0050, 16'h0003, 16'h0004, 0, 3'd0, 16'h0000, 16'h0003, 16'h0004, 4'h0, 3'd0, 0, 0};
    vecs[6]  = '{16'h9660, 16'h0100, 16'h2222, 0, 3'd0, 16'h0000, 16'h0100, 16'hFFE0, 4'h0, 3'd3, 1, 0};
    vecs[7]  = '{16'h7B80, 16'h00FF, 16'h1212, 0, 3'd0, 16'h0000, 16'h00FF, 16'h0000, 4'h7, 3'd5, 1, 0};
    vecs[8]  = '{16'h8DC0, 16'h0042, 16'h1313, 0, 3'd0, 16'h0000, 16'h0042, 16'h0000, 4'h8, 3'd6, 1, 0};
    vecs[9]  = '{16'h3E50, 16'h0001, 16'h2222, 1, 3'd2, 16'hAAAA, 16'h0001, 16'hAAAA, 4'h3, 3'd7, 1, 0};
    vecs[10] = '{16'hF000, 16'h6666, 16'h7777, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 4'h0, 3'd0, 0, 0};
    vecs[11] = '{16'h6218, 16'h5A5A, 16'h0F0F, 1, 3'd0, 16'hDEAD, 16'h0000, 16'h0F0F, 4'h6, 3'd1, 1, 0};
    vecs[12] = '{16'h5520, 16'h9999, 16'h9999, 1, 3'd4, 16'h1357, 16'h1357, 16'h1357, 4'h5, 3'd2, 1, 0};
    vecs[13] = '{16'h4298, 16'h8000, 16'h0003, 0, 3'd2, 16'hCAFE, 16'h8000, 16'h0003, 4'h4, 3'd1, 1, 0};

    reset = 1'b1; in_valid = 1'b0; in_instr = 16'h0000; rf_rdata1 = '0; rf_rdata2 = '0;
    fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0; flush = 1'b0; out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset in_ready", {15'd0, in_ready}, 16'd0);
    checkOutput("reset out_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("reset src_1", src_1, 16'h0000);
    checkOutput("reset alu_control", {12'd0, alu_control}, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("post-reset in_ready", {15'd0, in_ready}, 16'd1);

    // Streaming decode: one vector per cycle with the execute stage always ready.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      in_valid = 1'b1;
      #1;
      checkOutput($sformatf("v%0d rf_raddr1", i), {13'd0, rf_raddr1}, {13'd0, vecs[i].instr[8:6]});
      checkOutput($sformatf("v%0d rf_raddr2", i), {13'd0, rf_raddr2}, {13'd0, vecs[i].instr[5:3]});
      @(posedge clk); #1;
      checkDecoded($sformatf("v%0d", i), vecs[i]);
    end
    @(negedge clk);
    in_valid = 1'b0; fwd_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("drain out_valid", {15'd0, out_valid}, 16'd0);

    // Back-pressure: A in main, B in skid, C refused until skid drains.
    op_a = vecs[0]; op_a.rdata1 = 16'h000A; op_a.e_src1 = 16'h000A; op_a.rdata2 = 16'h0001; op_a.e_src2 = 16'h0001;
    op_b = op_a; op_b.rdata1 = 16'h000B; op_b.e_src1 = 16'h000B;
    op_c = op_a; op_c.rdata1 = 16'h000C; op_c.e_src1 = 16'h000C;
    fillMainAndSkid(16'h000A, 16'h000B);
    checkOutput("bp in_ready", {15'd0, in_ready}, 16'd0);
    checkDecoded("bp A held", op_a);
    applyStimulus(op_c);
    @(posedge clk); #1;
    checkDecoded("bp A still held", op_a);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkDecoded("bp B", op_b);
    checkOutput("bp in_ready reopen", {15'd0, in_ready}, 16'd1);
    @(posedge clk); #1;
    checkDecoded("bp C", op_c);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("bp no duplicate", {15'd0, out_valid}, 16'd0);

    // Flush with both slots full and an op on offer.
    fillMainAndSkid(16'h0021, 16'h0022);
    flush = 1'b1;
    rf_rdata1 = 16'h0023;
    @(posedge clk); #1;
    checkOutput("flush out_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("flush in_ready", {15'd0, in_ready}, 16'd1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("flush stale %0d", k), {15'd0, out_valid}, 16'd0);
    end

    // Asynchronous reset in the middle of a stall.
    fillMainAndSkid(16'h0031, 16'h0032);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("areset out_valid", {15'd0, out_valid}, 16'd0);
    checkOutput("areset in_ready", {15'd0, in_ready}, 16'd0);
    checkOutput("areset src_1", src_1, 16'h0000);
    checkOutput("areset src_2", src_2, 16'h0000);
    checkOutput("areset out_rd", {13'd0, out_rd}, 16'd0);
    checkOutput("areset reg_write", {15'd0, out_reg_write}, 16'd0);
    checkOutput("areset illegal", {15'd0, out_illegal}, 16'd0);
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("areset recover in_ready", {15'd0, in_ready}, 16'd1);
    checkOutput("areset lost ops", {15'd0, out_valid}, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
